// File: rtl/tree_accum_pkg.sv
// Shared types and helpers for the tree adder result path.
package tree_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Widest accumulator the extend helper can produce.
    localparam int unsigned EXT_W = 64;

    // Extend the low in_width bits of data to EXT_W bits, sign- or zero-filling above.
    function automatic logic [EXT_W-1:0] extend(
        input logic [EXT_W-1:0] data,
        input int unsigned      in_width,
        input logic             signed_mode
    );
        logic [EXT_W-1:0] mask;
        logic             sign_bit;
        mask     = (in_width >= EXT_W) ? '1 : ((EXT_W'(1) << in_width) - EXT_W'(1));
        sign_bit = signed_mode & (|(data & mask & ~(mask >> 1)));
        extend   = (data & mask) | (sign_bit ? ~mask : '0);
    endfunction

endpackage

// File: rtl/partial_sum_accumulator.sv
// Folds a stream of tree-adder partial sums into one result per in_last-delimited group,
// with valid/ready on both sides and a registered result port.
module partial_sum_accumulator
    import tree_accum_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 10,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned MAX_COUNT = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_WIDTH-1:0]                in_data,
    input  logic                               in_last,
    input  logic                               signedAddition,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ACC_WIDTH-1:0]               out_data,
    output logic [$clog2(MAX_COUNT+1)-1:0]     out_beats,
    output logic                               out_overflow
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

    if (ACC_WIDTH < IN_WIDTH || MAX_COUNT < 1 || ACC_WIDTH > EXT_W) begin : g_param_check
        $fatal(1, "partial_sum_accumulator: illegal parameters");
    end

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ovf;
    logic                   r_mode;
    logic [ACC_WIDTH-1:0]   r_out_data;
    logic [CNT_W-1:0]       r_out_beats;
    logic                   r_out_overflow;

    logic                   w_accept;
    logic                   w_first;
    logic                   w_mode;
    logic [ACC_WIDTH-1:0]   w_ext;
    logic [ACC_WIDTH-1:0]   w_base;
    logic [ACC_WIDTH:0]     w_sum_full;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic                   w_beat_ovf;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_ovf_next;
    logic                   w_close;

    assign out_valid    = (r_state == HOLD);
    assign in_ready     = !out_valid || out_ready;
    assign out_data     = r_out_data;
    assign out_beats    = r_out_beats;
    assign out_overflow = r_out_overflow;

    // Any beat accepted outside ACCUM opens a fresh group and never sees the stale sum.
    assign w_accept     = in_valid && in_ready;
    assign w_first      = (r_state != ACCUM);
    assign w_mode       = w_first ? signedAddition : r_mode;
    assign w_ext        = ACC_WIDTH'(extend(EXT_W'(in_data), IN_WIDTH, w_mode));
    assign w_base       = w_first ? '0 : r_acc;
    assign w_sum_full   = {1'b0, w_base} + {1'b0, w_ext};
    assign w_sum        = w_sum_full[ACC_WIDTH-1:0];
    assign w_count_next = w_first ? CNT_W'(1) : r_count + CNT_W'(1);
    assign w_close      = in_last || (w_count_next == CNT_W'(MAX_COUNT));

    // Signed wrap: like-signed operands giving an opposite-signed sum; unsigned wrap: carry out.
    always_comb begin
        w_beat_ovf = 1'b0;
        if (!w_first) begin
            if (w_mode) begin
                w_beat_ovf = (w_base[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                             (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
            end else begin
                w_beat_ovf = w_sum_full[ACC_WIDTH];
            end
        end
    end

    assign w_ovf_next = (!w_first && r_ovf) || w_beat_ovf;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_close ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && w_close) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_next_state = w_close ? HOLD : ACCUM;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_ovf          <= 1'b0;
            r_mode         <= 1'b0;
            r_out_data     <= '0;
            r_out_beats    <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_acc   <= w_sum;
                r_count <= w_count_next;
                r_ovf   <= w_ovf_next;
                r_mode  <= w_mode;
                if (w_close) begin
                    r_out_data     <= w_sum;
                    r_out_beats    <= w_count_next;
                    r_out_overflow <= w_ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Randomized and directed checks of partial_sum_accumulator across several parameter sets.
module tb_partial_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] in_data;
    logic [7:0] in_data8;
    logic       in_last;
    logic       s_add;
    logic       out_ready;

    assign in_data8 = in_data[7:0];

    logic        d_in_ready, d_out_valid, d_out_ovf;
    logic [31:0] d_out_data;
    logic [4:0]  d_out_beats;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [9:0]  a_out_data;
    logic [4:0]  a_out_beats;

    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0]  b_out_data;
    logic [4:0]  b_out_beats;

    logic        m_in_ready, m_out_valid, m_out_ovf;
    logic [31:0] m_out_data;
    logic [2:0]  m_out_beats;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    partial_sum_accumulator #(.IN_WIDTH(10), .ACC_WIDTH(32), .MAX_COUNT(16)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
        .in_last(in_last), .signedAddition(s_add), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_data(d_out_data), .out_beats(d_out_beats), .out_overflow(d_out_ovf));

    partial_sum_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(10), .MAX_COUNT(16)) u_a10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data8),
        .in_last(in_last), .signedAddition(s_add), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_beats(a_out_beats), .out_overflow(a_out_ovf));

    partial_sum_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8), .MAX_COUNT(16)) u_a8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data8),
        .in_last(in_last), .signedAddition(s_add), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_beats(b_out_beats), .out_overflow(b_out_ovf));

    partial_sum_accumulator #(.IN_WIDTH(10), .ACC_WIDTH(32), .MAX_COUNT(4)) u_m4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
        .in_last(in_last), .signedAddition(s_add), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_data(m_out_data), .out_beats(m_out_beats), .out_overflow(m_out_ovf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [9:0] d, input logic l, input logic s, input logic r);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        s_add     = s;
        out_ready = r;
        tick();
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; s_add = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", d_out_valid); end
        n_tests++; if (d_out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", d_out_data); end
        n_tests++; if (d_out_beats !== 5'd0) begin n_fail++; $display("FAIL reset_beats: got %0d expected 0", d_out_beats); end
        n_tests++; if (d_out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", d_out_ovf); end
        n_tests++; if ({d_in_ready, a_in_ready, b_in_ready, m_in_ready} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1111", {d_in_ready, a_in_ready, b_in_ready, m_in_ready});
        end
    endtask

    task automatic test_signed();
        beat(10'h3FD, 1'b0, 1'b1, 1'b1);
        beat(10'h005, 1'b0, 1'b1, 1'b1);
        n_tests++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL signed_early_valid: got %0b expected 0", d_out_valid); end
        beat(10'h3FF, 1'b1, 1'b1, 1'b1);
        n_tests++; if (d_out_valid !== 1'b1) begin n_fail++; $display("FAIL signed_valid: got %0b expected 1", d_out_valid); end
        n_tests++; if (d_out_data !== 32'd1) begin n_fail++; $display("FAIL signed_data: got %0h expected 1", d_out_data); end
        n_tests++; if (d_out_beats !== 5'd3) begin n_fail++; $display("FAIL signed_beats: got %0d expected 3", d_out_beats); end
        n_tests++; if (d_out_ovf !== 1'b0) begin n_fail++; $display("FAIL signed_ovf: got %0b expected 0", d_out_ovf); end
        idle();
        n_tests++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL signed_taken: got %0b expected 0", d_out_valid); end
    endtask

    task automatic test_unsigned();
        beat(10'h3FF, 1'b0, 1'b0, 1'b1);
        beat(10'h001, 1'b1, 1'b0, 1'b1);
        n_tests++; if (d_out_data !== 32'h400) begin n_fail++; $display("FAIL unsigned_data: got %0h expected 400", d_out_data); end
        n_tests++; if (d_out_beats !== 5'd2) begin n_fail++; $display("FAIL unsigned_beats: got %0d expected 2", d_out_beats); end
        idle();
        beat(10'h3FF, 1'b0, 1'b1, 1'b1);
        beat(10'h001, 1'b1, 1'b1, 1'b1);
        n_tests++; if (d_out_data !== 32'h0) begin n_fail++; $display("FAIL resigned_data: got %0h expected 0", d_out_data); end
        n_tests++; if (d_out_ovf !== 1'b0) begin n_fail++; $display("FAIL resigned_ovf: got %0b expected 0", d_out_ovf); end
        idle();
    endtask

    task automatic test_width();
        beat(10'd100, 1'b0, 1'b1, 1'b1);
        beat(10'd100, 1'b0, 1'b1, 1'b1);
        beat(10'd100, 1'b1, 1'b1, 1'b1);
        n_tests++; if (a_out_data !== 10'd300) begin n_fail++; $display("FAIL acc10_data: got %0d expected 300", a_out_data); end
        n_tests++; if (a_out_ovf !== 1'b0) begin n_fail++; $display("FAIL acc10_ovf: got %0b expected 0", a_out_ovf); end
        n_tests++; if (a_out_beats !== 5'd3) begin n_fail++; $display("FAIL acc10_beats: got %0d expected 3", a_out_beats); end
        idle();
        beat(10'd100, 1'b0, 1'b1, 1'b1);
        beat(10'd100, 1'b1, 1'b1, 1'b1);
        n_tests++; if (b_out_data !== 8'hC8) begin n_fail++; $display("FAIL acc8_data: got %0h expected c8", b_out_data); end
        n_tests++; if (b_out_ovf !== 1'b1) begin n_fail++; $display("FAIL acc8_ovf: got %0b expected 1", b_out_ovf); end
        n_tests++; if (b_out_beats !== 5'd2) begin n_fail++; $display("FAIL acc8_beats: got %0d expected 2", b_out_beats); end
        idle();
    endtask

    task automatic test_backpressure();
        beat(10'd4, 1'b0, 1'b0, 1'b0);
        beat(10'd9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 10'd99; in_last = 1'b0; out_ready = 1'b0;
            #1;
            n_tests++; if (d_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", i, d_in_ready); end
            tick();
            n_tests++; if ({d_out_valid, d_out_data, d_out_beats, d_out_ovf} !== {1'b1, 32'd13, 5'd2, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0d b=%0d o=%0b expected v=1 d=13 b=2 o=0",
                                   i, d_out_valid, d_out_data, d_out_beats, d_out_ovf);
            end
        end
        in_data = 10'd7; in_last = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (d_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", d_in_ready); end
        tick();
        n_tests++; if ({d_out_valid, d_out_data, d_out_beats} !== {1'b1, 32'd7, 5'd1}) begin
            n_fail++; $display("FAIL bp_next: got v=%0b d=%0d b=%0d expected v=1 d=7 b=1", d_out_valid, d_out_data, d_out_beats);
        end
        idle();
    endtask

    task automatic test_max_count();
        for (int i = 0; i < 4; i++) beat(10'd1, 1'b0, 1'b0, 1'b1);
        n_tests++; if ({m_out_valid, m_out_data, m_out_beats} !== {1'b1, 32'd4, 3'd4}) begin
            n_fail++; $display("FAIL max_first: got v=%0b d=%0d b=%0d expected v=1 d=4 b=4", m_out_valid, m_out_data, m_out_beats);
        end
        beat(10'd1, 1'b0, 1'b0, 1'b1);
        n_tests++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL max_open: got %0b expected 0", m_out_valid); end
        beat(10'd0, 1'b1, 1'b0, 1'b1);
        n_tests++; if ({m_out_valid, m_out_data, m_out_beats} !== {1'b1, 32'd1, 3'd2}) begin
            n_fail++; $display("FAIL max_second: got v=%0b d=%0d b=%0d expected v=1 d=1 b=2", m_out_valid, m_out_data, m_out_beats);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        beat(10'd5, 1'b0, 1'b0, 1'b1);
        beat(10'd6, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        n_tests++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b expected 0", d_out_valid); end
        beat(10'd2, 1'b1, 1'b0, 1'b1);
        n_tests++; if ({d_out_valid, d_out_data, d_out_beats} !== {1'b1, 32'd2, 5'd1}) begin
            n_fail++; $display("FAIL rstmid_result: got v=%0b d=%0d b=%0d expected v=1 d=2 b=1", d_out_valid, d_out_data, d_out_beats);
        end
        idle();
    endtask

    // Reference: each group is an exact integer sum wrapped into the 32-bit range after every beat.
    task automatic test_random();
        bit          g_open = 1'b0;
        bit          g_mode = 1'b0;
        longint      g_v = 0;
        int          g_beats = 0;
        bit          g_ovf = 1'b0;
        bit          e_valid = 1'b0;
        logic [31:0] e_data = '0;
        int          e_beats = 0;
        bit          e_ovf = 1'b0;
        longint      x;
        bit          acc;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            in_data   = 10'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            s_add     = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_tests++; if (d_in_ready !== (!e_valid || out_ready)) begin
                n_fail++; $display("FAIL rnd_in_ready[%0d]: got %0b expected %0b", c, d_in_ready, !e_valid || out_ready);
            end
            acc = in_valid && (!e_valid || out_ready);
            if (e_valid && out_ready) e_valid = 1'b0;
            if (acc) begin
                if (!g_open) begin
                    g_mode = s_add; g_v = 0; g_beats = 0; g_ovf = 1'b0;
                end
                x = (g_mode && in_data >= 10'd512) ? longint'(in_data) - 1024 : longint'(in_data);
                if (g_beats == 0) begin
                    g_v = g_mode ? x : (x < 0 ? x + 64'sd4294967296 : x);
                end else begin
                    g_v = g_v + x;
                    if (g_mode) begin
                        if (g_v > 64'sd2147483647) begin g_v -= 64'sd4294967296; g_ovf = 1'b1; end
                        if (g_v < -64'sd2147483648) begin g_v += 64'sd4294967296; g_ovf = 1'b1; end
                    end else if (g_v >= 64'sd4294967296) begin
                        g_v -= 64'sd4294967296; g_ovf = 1'b1;
                    end
                end
                g_beats++;
                g_open = 1'b1;
                if (in_last || g_beats == 16) begin
                    e_valid = 1'b1; e_data = 32'(g_v); e_beats = g_beats; e_ovf = g_ovf;
                    g_open = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            n_tests++; if (d_out_valid !== e_valid) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", c, d_out_valid, e_valid);
            end
            if (e_valid) begin
                n_tests++; if ({d_out_data, d_out_beats, d_out_ovf} !== {e_data, 5'(e_beats), e_ovf}) begin
                    n_fail++; $display("FAIL rnd_result[%0d]: got d=%0h b=%0d o=%0b expected d=%0h b=%0d o=%0b",
                                       c, d_out_data, d_out_beats, d_out_ovf, e_data, e_beats, e_ovf);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_width();
        test_backpressure();
        test_max_count();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
